// File: rtl/sparc_ctrl_pkg.sv
// rtl/sparc_ctrl_pkg.sv - state encoding, opcode constants and select encodings for the SPARC control unit
package sparc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_INIT, S_F0, S_F1, S_DEC,
        S_ALU, S_SETHI, S_BR, S_CALL0, S_CALL1, S_NXT,
        S_L0, S_L1, S_L2, S_S0, S_S1, S_S2,
        S_ERROR
    } state_t;

    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    localparam logic [2:0] OP2_SETHI = 3'b100;
    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;

    // Must track the ALU's own op decode.
    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_PASSA = 6'b111101;
    localparam logic [5:0] ALU_PASSB = 6'b111110;

    localparam logic [1:0] MB_PORTB = 2'd0;
    localparam logic [1:0] MB_IMM   = 2'd1;
    localparam logic [1:0] MB_PC    = 2'd2;
    localparam logic [1:0] MB_MDR   = 2'd3;

    localparam logic MM_RAM = 1'b0;
    localparam logic MM_ALU = 1'b1;

    localparam logic [1:0] MNP_ALU  = 2'd0;
    localparam logic [1:0] MNP_NPC8 = 2'd1;
    localparam logic [1:0] MNP_DISP = 2'd2;
    localparam logic [1:0] MNP_NPC4 = 2'd3;

    localparam logic [1:0] MP_ZERO = 2'd0;
    localparam logic [1:0] MP_TBR  = 2'd1;
    localparam logic [1:0] MP_NPC4 = 2'd2;
    localparam logic [1:0] MP_NPC  = 2'd3;

    localparam logic MSA_RS1 = 1'b0;
    localparam logic MSA_RD  = 1'b1;

    localparam logic [1:0] MSC_RD  = 2'd0;
    localparam logic [1:0] MSC_R15 = 2'd1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [1:0] access_size(input logic [1:0] op3_lo);
        case (op3_lo)
            2'b01:   return SZ_BYTE;
            2'b10:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - memory wait cycle counter with clear and expiry flag
module ctrl_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(WAIT_LIMIT));

    // Saturates at the limit so a stalled counter never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sparc_control_unit.sv
// rtl/sparc_control_unit.sv - hardwired fetch/decode/execute FSM driving the SPARC-subset datapath
module sparc_control_unit
    import sparc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IR,
    input  logic        MOC,
    input  logic        BCOND,
    output logic        MAR_Ld,
    output logic        MDR_Ld,
    output logic        IR_Ld,
    output logic        PC_Ld,
    output logic        NPC_Ld,
    output logic        nPC_Clr,
    output logic        FR_Ld,
    output logic        RF_Load_Enable,
    output logic        MOV,
    output logic        RW,
    output logic [1:0]  mem_type,
    output logic [1:0]  MB,
    output logic        MM,
    output logic [1:0]  MNP,
    output logic [1:0]  MP,
    output logic        MSa,
    output logic [1:0]  MSc,
    output logic        MOP,
    output logic [5:0]  OpXX,
    output logic        mem_err,
    output logic        illegal
);

    state_t     state, next_state;
    logic       in_wait, expired;
    logic       set_mem_err, set_illegal;
    logic       imm;
    logic [5:0] op3;
    logic [2:0] op2;
    logic [1:0] size;
    logic       unused_ir;

    assign imm       = IR[13];
    assign op3       = IR[24:19];
    assign op2       = IR[24:22];
    assign size      = access_size(IR[20:19]);
    assign unused_ir = ^{IR[28:25], IR[18:14], IR[12:0]};

    // Wait states are never adjacent, so holding the counter clear outside them
    // guarantees it starts at zero on every entry.
    assign in_wait = (state == S_F1) || (state == S_L1) || (state == S_S2);

    ctrl_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (Clk),
        .rst     (Clr),
        .clear   (!in_wait),
        .en      (in_wait && !MOC),
        .expired (expired)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state   <= S_RST;
            mem_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (set_mem_err) mem_err <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

    always_comb begin
        next_state     = state;
        set_mem_err    = 1'b0;
        set_illegal    = 1'b0;
        MAR_Ld         = 1'b0;
        MDR_Ld         = 1'b0;
        IR_Ld          = 1'b0;
        PC_Ld          = 1'b0;
        NPC_Ld         = 1'b0;
        nPC_Clr        = 1'b0;
        FR_Ld          = 1'b0;
        RF_Load_Enable = 1'b0;
        MOV            = 1'b0;
        RW             = 1'b0;
        mem_type       = 2'b00;
        MB             = MB_PORTB;
        MM             = MM_RAM;
        MNP            = MNP_ALU;
        MP             = MP_ZERO;
        MSa            = MSA_RS1;
        MSc            = MSC_RD;
        MOP            = 1'b0;
        OpXX           = 6'b000000;

        case (state)
            S_RST: begin
                PC_Ld      = 1'b1;
                MP         = MP_ZERO;
                nPC_Clr    = 1'b1;
                next_state = S_INIT;
            end
            S_INIT: begin
                NPC_Ld     = 1'b1;
                MNP        = MNP_NPC4;
                next_state = S_F0;
            end
            S_F0: begin
                MAR_Ld     = 1'b1;
                MB         = MB_PC;
                MOP        = 1'b1;
                OpXX       = ALU_PASSB;
                next_state = S_F1;
            end
            S_F1: begin
                MOV      = 1'b1;
                RW       = 1'b1;
                mem_type = SZ_WORD;
                if (MOC) begin
                    IR_Ld      = 1'b1;
                    next_state = S_DEC;
                end else if (expired) begin
                    set_mem_err = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_DEC: begin
                case (IR[31:30])
                    OP_ALU:  next_state = S_ALU;
                    OP_CALL: next_state = S_CALL0;
                    OP_FMT2: begin
                        if (op2 == OP2_SETHI)     next_state = S_SETHI;
                        else if (op2 == OP2_BICC) next_state = S_BR;
                        else begin
                            set_illegal = 1'b1;
                            next_state  = S_ERROR;
                        end
                    end
                    default: begin
                        case (op3)
                            OP3_LD, OP3_LDUB, OP3_LDUH: next_state = S_L0;
                            OP3_ST, OP3_STB, OP3_STH:   next_state = S_S0;
                            default: begin
                                set_illegal = 1'b1;
                                next_state  = S_ERROR;
                            end
                        endcase
                    end
                endcase
            end
            S_ALU: begin
                RF_Load_Enable = 1'b1;
                MB             = imm ? MB_IMM : MB_PORTB;
                MSc            = MSC_RD;
                FR_Ld          = IR[23];
                next_state     = S_NXT;
            end
            S_SETHI: begin
                RF_Load_Enable = 1'b1;
                MB             = MB_IMM;
                MOP            = 1'b1;
                OpXX           = ALU_PASSB;
                next_state     = S_NXT;
            end
            S_CALL0: begin
                RF_Load_Enable = 1'b1;
                MSc            = MSC_R15;
                MB             = MB_PC;
                MOP            = 1'b1;
                OpXX           = ALU_PASSB;
                next_state     = S_CALL1;
            end
            S_CALL1: begin
                PC_Ld      = 1'b1;
                MP         = MP_NPC;
                NPC_Ld     = 1'b1;
                MNP        = MNP_DISP;
                next_state = S_F0;
            end
            S_BR: begin
                PC_Ld  = 1'b1;
                NPC_Ld = 1'b1;
                if (BCOND) begin
                    MP  = MP_NPC;
                    MNP = MNP_DISP;
                end else if (IR[29]) begin
                    MP  = MP_NPC4;
                    MNP = MNP_NPC8;
                end else begin
                    MP  = MP_NPC;
                    MNP = MNP_NPC4;
                end
                next_state = S_F0;
            end
            S_NXT: begin
                PC_Ld      = 1'b1;
                MP         = MP_NPC;
                NPC_Ld     = 1'b1;
                MNP        = MNP_NPC4;
                next_state = S_F0;
            end
            S_L0, S_S0: begin
                MAR_Ld     = 1'b1;
                MSa        = MSA_RS1;
                MB         = imm ? MB_IMM : MB_PORTB;
                MOP        = 1'b1;
                OpXX       = ALU_ADD;
                next_state = (state == S_L0) ? S_L1 : S_S1;
            end
            S_L1: begin
                MOV      = 1'b1;
                RW       = 1'b1;
                mem_type = size;
                if (MOC) begin
                    MDR_Ld     = 1'b1;
                    MM         = MM_RAM;
                    next_state = S_L2;
                end else if (expired) begin
                    set_mem_err = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_L2: begin
                RF_Load_Enable = 1'b1;
                MB             = MB_MDR;
                MOP            = 1'b1;
                OpXX           = ALU_PASSB;
                MSc            = MSC_RD;
                next_state     = S_NXT;
            end
            S_S1: begin
                MDR_Ld     = 1'b1;
                MM         = MM_ALU;
                MSa        = MSA_RD;
                MOP        = 1'b1;
                OpXX       = ALU_PASSA;
                next_state = S_S2;
            end
            S_S2: begin
                MOV      = 1'b1;
                RW       = 1'b0;
                mem_type = size;
                if (MOC) begin
                    next_state = S_NXT;
                end else if (expired) begin
                    set_mem_err = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_sparc_control_unit.sv
// tb/tb_sparc_control_unit.sv - randomized instruction stream checked against per-instruction control traces
module tb_sparc_control_unit;

    localparam int WAIT_LIMIT = 15;

    logic        Clk = 1'b0;
    logic        Clr, MOC, BCOND;
    logic [31:0] IR;
    logic        MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable;
    logic        MOV, RW, MM, MSa, MOP, mem_err, illegal;
    logic [1:0]  mem_type, MB, MNP, MP, MSc;
    logic [5:0]  OpXX;

    typedef struct packed {
        logic       mar, mdr, ir, pc, npc, nclr, fr, rf, mov, rw;
        logic [1:0] ty, mb;
        logic       mm;
        logic [1:0] mnp, mp;
        logic       msa;
        logic [1:0] msc;
        logic       mop;
        logic [5:0] opxx;
    } ctl_t;

    ctl_t act;
    int   passed = 0;
    int   total  = 0;

    always #5 Clk = ~Clk;

    sparc_control_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .Clk(Clk), .Clr(Clr), .IR(IR), .MOC(MOC), .BCOND(BCOND),
        .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .NPC_Ld(NPC_Ld),
        .nPC_Clr(nPC_Clr), .FR_Ld(FR_Ld), .RF_Load_Enable(RF_Load_Enable), .MOV(MOV), .RW(RW),
        .mem_type(mem_type), .MB(MB), .MM(MM), .MNP(MNP), .MP(MP), .MSa(MSa), .MSc(MSc),
        .MOP(MOP), .OpXX(OpXX), .mem_err(mem_err), .illegal(illegal)
    );

    assign act = {MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable, MOV, RW,
                  mem_type, MB, MM, MNP, MP, MSa, MSc, MOP, OpXX};

    // Expected control words, one per phase of the instruction walk.
    function automatic ctl_t e_idle();
        return '0;
    endfunction
    function automatic ctl_t e_rst();
        ctl_t e = '0; e.pc = 1; e.mp = 2'd0; e.nclr = 1; return e;
    endfunction
    function automatic ctl_t e_init();
        ctl_t e = '0; e.npc = 1; e.mnp = 2'd3; return e;
    endfunction
    function automatic ctl_t e_f0();
        ctl_t e = '0; e.mar = 1; e.mb = 2'd2; e.mop = 1; e.opxx = 6'b111110; return e;
    endfunction
    function automatic ctl_t e_f1(input logic moc);
        ctl_t e = '0; e.mov = 1; e.rw = 1; e.ty = 2'b10; e.ir = moc; return e;
    endfunction
    function automatic ctl_t e_alu(input logic i, input logic cc);
        ctl_t e = '0; e.rf = 1; e.mb = {1'b0, i}; e.fr = cc; return e;
    endfunction
    function automatic ctl_t e_sethi();
        ctl_t e = '0; e.rf = 1; e.mb = 2'd1; e.mop = 1; e.opxx = 6'b111110; return e;
    endfunction
    function automatic ctl_t e_call0();
        ctl_t e = '0; e.rf = 1; e.msc = 2'd1; e.mb = 2'd2; e.mop = 1; e.opxx = 6'b111110; return e;
    endfunction
    function automatic ctl_t e_xfer(input logic [1:0] mp, input logic [1:0] mnp);
        ctl_t e = '0; e.pc = 1; e.npc = 1; e.mp = mp; e.mnp = mnp; return e;
    endfunction
    function automatic ctl_t e_addr(input logic i);
        ctl_t e = '0; e.mar = 1; e.mb = {1'b0, i}; e.mop = 1; e.opxx = 6'b000000; return e;
    endfunction
    function automatic ctl_t e_l1(input logic [1:0] sz, input logic moc);
        ctl_t e = '0; e.mov = 1; e.rw = 1; e.ty = sz; e.mdr = moc; return e;
    endfunction
    function automatic ctl_t e_l2();
        ctl_t e = '0; e.rf = 1; e.mb = 2'd3; e.mop = 1; e.opxx = 6'b111110; return e;
    endfunction
    function automatic ctl_t e_s1();
        ctl_t e = '0; e.mdr = 1; e.mm = 1; e.msa = 1; e.mop = 1; e.opxx = 6'b111101; return e;
    endfunction
    function automatic ctl_t e_s2(input logic [1:0] sz);
        ctl_t e = '0; e.mov = 1; e.rw = 0; e.ty = sz; return e;
    endfunction

    // Access size from the low op3 bits: word, byte, half.
    function automatic logic [1:0] exp_size(input logic [1:0] lo);
        logic [1:0] tab [0:2];
        tab[0] = 2'b10; tab[1] = 2'b00; tab[2] = 2'b01;
        return (lo == 2'b11) ? 2'b10 : tab[lo];
    endfunction

    task automatic chk(input ctl_t exp, input string tag);
        #1;
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed %h required %h", tag, act, exp);
        @(negedge Clk);
    endtask

    task automatic chk_flags(input logic me, input logic il, input string tag);
        #1;
        total++;
        assert ({mem_err, illegal} === {me, il}) passed++;
        else $error("FAIL %s: observed mem_err/illegal %b%b required %b%b", tag, mem_err, illegal, me, il);
    endtask

    task automatic fetch(input logic [31:0] ir, input int d);
        IR = ir; MOC = 0;
        chk(e_f0(), "f0");
        for (int c = 0; c <= d; c++) begin
            MOC = (c == d);
            chk(e_f1(MOC), "f1");
        end
        MOC = 0;
        chk(e_idle(), "dec");
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic bc, input int df, input int dm);
        logic [1:0] sz;
        sz = exp_size(ir[20:19]);
        fetch(ir, df);
        BCOND = bc;
        case (ir[31:30])
            2'b10: begin
                chk(e_alu(ir[13], ir[23]), "alu");
                chk(e_xfer(2'd3, 2'd3), "alu_nxt");
            end
            2'b01: begin
                chk(e_call0(), "call0");
                chk(e_xfer(2'd3, 2'd2), "call1");
            end
            2'b00: begin
                if (ir[24:22] == 3'b100) begin
                    chk(e_sethi(), "sethi");
                    chk(e_xfer(2'd3, 2'd3), "sethi_nxt");
                end else if (bc) chk(e_xfer(2'd3, 2'd2), "br_taken");
                else if (ir[29]) chk(e_xfer(2'd2, 2'd1), "br_annul");
                else chk(e_xfer(2'd3, 2'd3), "br_fall");
            end
            default: begin
                chk(e_addr(ir[13]), "ls_addr");
                if (ir[21] == 1'b0) begin
                    for (int c = 0; c <= dm; c++) begin
                        MOC = (c == dm);
                        chk(e_l1(sz, MOC), "l1");
                    end
                    MOC = 0;
                    chk(e_l2(), "l2");
                end else begin
                    chk(e_s1(), "s1");
                    for (int c = 0; c <= dm; c++) begin
                        MOC = (c == dm);
                        chk(e_s2(sz), "s2");
                    end
                    MOC = 0;
                end
                chk(e_xfer(2'd3, 2'd3), "ls_nxt");
            end
        endcase
        BCOND = 0;
    endtask

    task automatic do_reset();
        Clr = 1; MOC = 0; BCOND = 0; IR = 32'h0;
        @(negedge Clk);
        chk(e_rst(), "clr_hold");
        Clr = 0;
        chk_flags(1'b0, 1'b0, "flags_reset");
        chk(e_rst(), "rst");
        chk(e_init(), "init");
    endtask

    initial begin
        logic [31:0] r, ir;
        int          k;

        do_reset();

        // Directed: ADD imm, MOC after two wait cycles.
        run_instr(32'h82006005, 1'b0, 2, 0);
        // Directed: LDUB and STH.
        run_instr({2'b11, 5'd3, 6'b000001, 5'd2, 1'b1, 13'h10}, 1'b0, 0, 1);
        run_instr({2'b11, 5'd3, 6'b000110, 5'd2, 1'b0, 13'h0}, 1'b0, 1, 0);
        // Directed: Bicc annul with BCOND low then high, and CALL.
        run_instr({2'b00, 1'b1, 4'h8, 3'b010, 22'h10}, 1'b0, 0, 0);
        run_instr({2'b00, 1'b1, 4'h8, 3'b010, 22'h10}, 1'b1, 0, 0);
        run_instr({2'b00, 1'b0, 4'h8, 3'b010, 22'h10}, 1'b0, 0, 0);
        run_instr({2'b01, 30'h40}, 1'b0, 0, 0);
        // MOC on the last allowed wait cycle must still be accepted.
        run_instr({2'b10, 5'd1, 6'b010000, 5'd1, 1'b0, 13'h2}, 1'b0, WAIT_LIMIT, 0);
        run_instr({2'b11, 5'd4, 6'b000000, 5'd1, 1'b1, 13'h4}, 1'b0, 0, WAIT_LIMIT);

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            k = $urandom_range(0, 7);
            case (k)
                0: ir = {2'b10, r[29:0]};
                1: ir = {2'b00, r[29:25], 3'b100, r[21:0]};
                2: ir = {2'b00, r[29:25], 3'b010, r[21:0]};
                3: ir = {2'b01, r[29:0]};
                4, 5: ir = {2'b11, r[29:25], 4'b0000, 2'($urandom_range(0, 2)), r[18:0]};
                default: ir = {2'b11, r[29:25], 4'b0001, 2'($urandom_range(0, 2)), r[18:0]};
            endcase
            run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(0, WAIT_LIMIT), $urandom_range(0, WAIT_LIMIT));
        end

        // Store whose MOC never arrives: 16 wait cycles, then ERROR.
        fetch({2'b11, 5'd5, 6'b000101, 5'd1, 1'b1, 13'h8}, 0);
        chk(e_addr(1'b1), "to_addr");
        chk(e_s1(), "to_s1");
        for (int c = 0; c <= WAIT_LIMIT; c++) chk(e_s2(2'b00), "to_s2_wait");
        chk_flags(1'b1, 1'b0, "mem_err_set");
        chk(e_idle(), "error_0");
        MOC = 1; BCOND = 1;
        chk(e_idle(), "error_held");
        chk_flags(1'b1, 1'b0, "mem_err_sticky");
        MOC = 0; BCOND = 0;
        do_reset();

        // Unsupported memory op3 and unsupported format-2 op2.
        fetch(32'hC1E00000, 1);
        chk_flags(1'b0, 1'b1, "illegal_op3");
        chk(e_idle(), "illegal_err");
        do_reset();
        fetch({2'b00, 5'd0, 3'b000, 22'h0}, 0);
        chk_flags(1'b0, 1'b1, "illegal_op2");
        chk(e_idle(), "illegal_err2");
        do_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
